// File: rtl/keypad_scanner.sv
// Row-scanning front end for the 4x3 membrane keypad: finds a single pressed key,
// debounces press and release, and presents it as a one-hot digit level or */# flag.
module keypad_scanner #(
  parameter int ROW_DWELL = 2,
  parameter int DEBOUNCE  = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       key_star,
  output logic       key_hash,
  output logic       key_valid
);

  // state       | meaning
  // ST_SCAN     | walk rows, dwell ROW_DWELL cycles each, sample on last dwell cycle
  // ST_DEBOUNCE | candidate key latched, count matching samples
  // ST_HOLD     | key accepted, outputs held until latched column goes high
  // ST_RELEASE  | count consecutive high samples before dropping the key
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD, ST_RELEASE} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(ROW_DWELL - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE - 1);

  state_t     state;
  logic [1:0] row_idx;
  logic [1:0] lat_col;
  logic [2:0] lat_pat;
  logic [3:0] dwell_cnt;
  logic [3:0] deb_cnt;

  logic       one_low;
  logic [1:0] hit_col;
  logic       lat_high;
  logic [3:0] key_digit;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Two or more columns low on one row is a ghost/multi-press and is not a hit.
  always_comb begin
    one_low = 1'b1;
    hit_col = 2'd0;
    case (col_n)
      3'b110:  hit_col = 2'd0;
      3'b101:  hit_col = 2'd1;
      3'b011:  hit_col = 2'd2;
      default: one_low = 1'b0;
    endcase
  end

  assign lat_high  = col_n[lat_col];
  assign key_digit = ({2'b00, row_idx} * 4'd3) + {2'b00, lat_col} + 4'd1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      dwell_cnt <= 4'd0;
      deb_cnt   <= 4'd0;
      lat_col   <= 2'd0;
      lat_pat   <= 3'b111;
      row_n     <= 4'b1110;
      keypad    <= 10'd0;
      key_star  <= 1'b0;
      key_hash  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= 4'd0;
            if (one_low) begin
              lat_col <= hit_col;
              lat_pat <= col_n;
              deb_cnt <= 4'd0;
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              row_n   <= row_drive(row_idx + 2'd1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (col_n != lat_pat) begin
            deb_cnt <= 4'd0;
            row_idx <= row_idx + 2'd1;
            row_n   <= row_drive(row_idx + 2'd1);
            state   <= ST_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= 4'd0;
            key_valid <= 1'b1;
            state     <= ST_HOLD;
            // Bottom row carries *, 0, # rather than sequential digits.
            if (row_idx == 2'd3) begin
              key_star <= (lat_col == 2'd0);
              key_hash <= (lat_col == 2'd2);
              keypad   <= (lat_col == 2'd1) ? 10'd1 : 10'd0;
            end else begin
              keypad <= 10'd1 << key_digit;
            end
          end else begin
            deb_cnt <= deb_cnt + 4'd1;
          end
        end

        ST_HOLD: begin
          if (lat_high) begin
            deb_cnt <= 4'd0;
            state   <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!lat_high) begin
            state <= ST_HOLD;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= 4'd0;
            keypad    <= 10'd0;
            key_star  <= 1'b0;
            key_hash  <= 1'b0;
            row_idx   <= 2'd0;
            row_n     <= 4'b1110;
            dwell_cnt <= 4'd0;
            state     <= ST_SCAN;
          end else begin
            deb_cnt <= deb_cnt + 4'd1;
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a responsive matrix model drives col_n from row_n,
// and every key_valid strobe is matched against a queue of expected accepted keys.
module tb_keypad_scanner;

  logic       clk;
  logic       clear;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic       key_star;
  logic       key_hash;
  logic       key_valid;

  logic [1:0] press_row;
  logic [2:0] press_pat;
  logic       use_man;
  logic [2:0] man_col;

  typedef struct packed {
    logic [9:0] kp;
    logic       star;
    logic       hash;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  logic prev_valid;

  keypad_scanner #(.ROW_DWELL(2), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .clear     (clear),
    .col_n     (col_n),
    .row_n     (row_n),
    .keypad    (keypad),
    .key_star  (key_star),
    .key_hash  (key_hash),
    .key_valid (key_valid)
  );

  // Matrix model: the pressed pattern appears only while its row is driven low.
  assign col_n = use_man ? man_col :
                 ((row_n[press_row] == 1'b0) ? press_pat : 3'b111);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; at the following negedge match any key_valid strobe against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (key_valid) begin
      check("valid_back_to_back", 32'(prev_valid), 32'd0);
      check("unexpected_valid", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_keypad", 32'(keypad), 32'(e.kp));
        check("sb_star", 32'(key_star), 32'(e.star));
        check("sb_hash", 32'(key_hash), 32'(e.hash));
      end
    end
    prev_valid = key_valid;
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_row(input string tag, input logic [3:0] want);
    for (int i = 0; i < 20; i++) begin
      if (row_n == want) break;
      tick();
    end
    check(tag, 32'(row_n), 32'(want));
  endtask

  task automatic push(input logic [9:0] kp, input logic star, input logic hash);
    exp_t e;
    e.kp   = kp;
    e.star = star;
    e.hash = hash;
    sb.push_back(e);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    prev_valid = 1'b0;
    clear      = 1'b1;
    press_row  = 2'd0;
    press_pat  = 3'b111;
    use_man    = 1'b0;
    man_col    = 3'b111;

    // Reset values
    tick();
    check("rst_row_n", 32'(row_n), 32'h0000000e);
    check("rst_keypad", 32'(keypad), 32'd0);
    check("rst_flags", 32'({key_star, key_hash, key_valid}), 32'd0);
    tick();
    clear = 1'b0;

    // Idle scan: each row held for two cycles, walking 0..3
    check("idle_row_0", 32'(row_n), 32'h0000000e);
    for (int k = 1; k <= 40; k++) begin
      logic [3:0] exp_row;
      tick();
      exp_row = ~(4'b0001 << ((k / 2) % 4));
      check("idle_row", 32'(row_n), 32'(exp_row));
      check("idle_keypad", 32'(keypad), 32'd0);
    end

    // Digit 2 (row 0 / col 1): scanner is at row 0, dwell 0 here
    press_row = 2'd0;
    press_pat = 3'b101;
    push(10'b0000000100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("d2_not_yet", 32'(keypad), 32'd0);
    tick();
    check("d2_latency", 32'(keypad), 32'h004);
    for (int i = 0; i < 15; i++) tick();
    check("d2_hold", 32'(keypad), 32'h004);
    check("d2_hold_row", 32'(row_n), 32'h0000000e);
    press_pat = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    check("d2_release_early", 32'(keypad), 32'h004);
    tick();
    check("d2_released", 32'(keypad), 32'd0);
    check("d2_rescan_row", 32'(row_n), 32'h0000000e);
    check("d2_sb", 32'(sb.size()), 32'd0);

    // Digit 0 then # then * on the bottom row
    press_row = 2'd3;
    press_pat = 3'b101;
    push(10'b0000000001, 1'b0, 1'b0);
    wait_sb_empty("d0_timeout");
    check("d0_keypad", 32'(keypad), 32'h001);
    press_pat = 3'b111;
    for (int i = 0; i < 6; i++) tick();
    check("d0_released", 32'(keypad), 32'd0);

    press_pat = 3'b011;
    push(10'd0, 1'b0, 1'b1);
    wait_sb_empty("hash_timeout");
    check("hash_flag", 32'(key_hash), 32'd1);
    check("hash_keypad", 32'(keypad), 32'd0);
    press_pat = 3'b111;
    for (int i = 0; i < 6; i++) tick();
    check("hash_released", 32'(key_hash), 32'd0);

    press_pat = 3'b110;
    push(10'd0, 1'b1, 1'b0);
    wait_sb_empty("star_timeout");
    check("star_flag", 32'(key_star), 32'd1);
    press_pat = 3'b111;
    for (int i = 0; i < 6; i++) tick();
    check("star_released", 32'(key_star), 32'd0);

    // Bounce on digit 5: low for two cycles on row 1, then high
    wait_row("b5_find_row1", 4'b1101);
    use_man = 1'b1;
    man_col = 3'b101;
    tick();
    tick();
    man_col = 3'b111;
    tick();
    check("b5_scan_row2", 32'(row_n), 32'h0000000b);
    check("b5_keypad", 32'(keypad), 32'd0);
    use_man = 1'b0;

    // Digit 5 held, with a one-cycle release glitch and a second column pressed
    press_row = 2'd1;
    press_pat = 3'b101;
    push(10'b0000100000, 1'b0, 1'b0);
    wait_sb_empty("d5_timeout");
    check("d5_keypad", 32'(keypad), 32'h020);
    tick();
    use_man = 1'b1;
    man_col = 3'b111;
    tick();
    use_man = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("d5_glitch_hold", 32'(keypad), 32'h020);
    press_pat = 3'b001;
    for (int i = 0; i < 5; i++) tick();
    check("d5_rollover_ignored", 32'(keypad), 32'h020);
    press_pat = 3'b111;
    for (int i = 0; i < 6; i++) tick();
    check("d5_released", 32'(keypad), 32'd0);

    // Multi-press on row 0 is ignored and scanning continues
    press_row = 2'd0;
    wait_row("mp_find_row0", 4'b1110);
    press_pat = 3'b100;
    wait_row("mp_advance", 4'b1101);
    for (int i = 0; i < 12; i++) tick();
    check("mp_keypad", 32'(keypad), 32'd0);
    check("mp_flags", 32'({key_star, key_hash}), 32'd0);
    press_pat = 3'b111;

    // Digit 9 held, then asynchronous clear between clock edges
    press_row = 2'd2;
    press_pat = 3'b011;
    push(10'b1000000000, 1'b0, 1'b0);
    wait_sb_empty("d9_timeout");
    check("d9_keypad", 32'(keypad), 32'h200);
    tick();
    #2 clear = 1'b1;
    #1;
    check("async_keypad", 32'(keypad), 32'd0);
    check("async_row_n", 32'(row_n), 32'h0000000e);
    press_pat = 3'b111;
    tick();
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_keypad", 32'(keypad), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front end for the microwave keypad: scans a 4x3 membrane matrix (phone layout), debounces a single key press and drives the 10-bit one-hot digit bus consumed by controler.
- Produces a stable one-hot level for as long as the key is held, plus a one-cycle press strobe.
- Handles * and # as separate level flags; they never appear on the digit bus.
- Sits between the board pins and controler.keypad on the same clk domain.

Parameters:
- ROW_DWELL, 2, clk cycles each row is driven low before its columns are sampled; legal range 1..15.
- DEBOUNCE, 3, consecutive matching samples required to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  system clock (100 Hz on the board).
- clear  input  1  asynchronous, active-high reset.
- col_n  input  3  matrix column sense, active-low, externally pulled up. Bit c = column c.
- row_n  output  4  matrix row drive, active-low, exactly one bit low at all times.
- keypad  output  10  one-hot digit bus, bit d = digit d. All-zero when no digit key is accepted.
- key_star  output  1  level, * accepted and held.
- key_hash  output  1  level, # accepted and held.
- key_valid  output  1  one-cycle strobe on the cycle any key (digit, *, #) is first accepted.

Behaviour:
- Key map (row r, col c):
  - For r = 0..2: digit 3r+c+1.
  - Row 3: col0 = *, col1 = 0, col2 = #.
- Reset (clear=1, asynchronous) forces the following; clear has priority in every state, including mid-debounce and HOLD:
  - row_n=4'b1110, keypad=0, key_star=0, key_hash=0, key_valid=0.
  - State SCAN, row index 0, dwell and debounce counters 0.
- All outputs are registered.
- FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
- SCAN:
  - Drive row index r low for ROW_DWELL cycles, then sample col_n on the last dwell cycle.
  - Exactly one col_n bit low: latch (r, c), clear the debounce counter, enter DEBOUNCE; row_n stays on row r.
  - No bit low, or 2+ bits low (ghost/multi-press): advance r = (r+1) mod 4, wrapping 3 -> 0, and restart dwell.
- DEBOUNCE:
  - Row r stays driven; col_n is sampled every cycle.
  - A sample equal to the latched single-low pattern increments the counter.
  - Any mismatch abandons the candidate: counter cleared, go to SCAN at (r+1) mod 4, no outputs change.
  - On the DEBOUNCE-th match, the next edge loads the outputs for the mapped key (keypad one-hot or key_star/key_hash), asserts key_valid for exactly one cycle, and enters HOLD.
  - Latency: the key is first seen low at sample cycle T and stays stable. Outputs are high from cycle T+DEBOUNCE+1.
- HOLD:
  - Outputs held constant, key_valid=0, row r held.
  - Any sample where the latched column is high enters RELEASE with the counter cleared.
  - Other columns going low are ignored; there is no rollover and no second key_valid.
- RELEASE:
  - Outputs still held.
  - Each sample with the latched column high increments the counter.
  - A sample with the latched column low returns to HOLD; this is contact bounce and produces no new strobe.
  - On the DEBOUNCE-th consecutive high sample: keypad, key_star and key_hash clear on the next edge, go to SCAN with r reset to 0.
- Invariants:
  - keypad is zero or one-hot.
  - At most one of {keypad!=0, key_star, key_hash} is true.
  - key_valid is never high in two consecutive cycles.
- Worst-case scan latency before detection: 4*ROW_DWELL cycles.

Test Plan:
- Idle: clear pulse, col_n=3'b111 for 40 cycles -> row_n cycles 1110,1101,1011,0111 with each value held 2 cycles; keypad=0; key_valid never high.
- Digit 2: hold col_n[1]=0 whenever row_n=1110, for 20 cycles -> keypad=10'b0000000100 from T+4, one key_valid pulse. Release for 4+ cycles -> keypad=0, scan restarts at 1110.
- Digit 0 and #:
  - Press row3/col1 -> keypad=10'b0000000001.
  - Later press row3/col2 -> key_hash=1, keypad=0, key_valid pulse each time.
- Bounce:
  - Digit 5 (row1/col1) low for 2 cycles then high -> no output, scan resumes at row 2.
  - During HOLD of 5, one high glitch cycle -> keypad stays 10'b0000100000, no extra key_valid.
- Multi-press: col_n=3'b100 while row 0 is driven -> ignored, scan advances, outputs stay 0.
- Reset mid-operation: assert clear asynchronously (between clk edges) while HOLD shows digit 9 -> keypad=0 and row_n=1110 immediately, before the next clk edge.
